onchip_memory_port_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that sits directly upstream of one port of the shared dual-port on-chip memory (15-bit word address, 32-bit data, byte enables, 1-cycle read latency). It lets two cores share a single memory port. It grants one command per cycle in round-robin order, drives the memory's chipselect/write/address/byteenable/writedata, and returns read data with `readdatavalid` to the requester that issued the read.

---
 rtl/onchip_memory_port_arbiter_pkg.sv | 16 +
 rtl/onchip_memory_port_arbiter_if.sv | 50 +++++
 rtl/onchip_memory_port_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/onchip_memory_port_arbiter.sv | 94 +++++++++
 tb/tb_onchip_memory_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_memory_port_arbiter_pkg.sv
// Shared widths and read-tracking tag for the
// two-requester on-chip memory port arbiter.
package onchip_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/onchip_memory_port_arbiter_if.sv
// Avalon-MM requester port and single memory port
// bundles used around the arbiter.
interface onchip_memory_port_arbiter_if;
  import onchip_mem_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write,
    output writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write,
    input  writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

interface onchip_mem_port_if;
  import onchip_mem_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect,
    output write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect,
    input  write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_memory_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the requester that
// did not win last time wins a contention.
module rr_arbiter2
  import onchip_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_t last_grant_q;
  req_id_t last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (reset_n) begin
      unique case (1'b1)
        (req == 2'b01): grant = 2'b01;
        (req == 2'b10): grant = 2'b10;
        (req == 2'b11):
          grant = last_grant_q ? 2'b01 : 2'b10;
        default:        grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[0])      last_grant_d = 1'b0;
    else if (grant[1]) last_grant_d = 1'b1;
  end

  // Reset to m1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/onchip_memory_port_arbiter.sv
// Shares one on-chip memory port between two cores:
// same-cycle command mux plus read-owner tracking.
module onchip_memory_port_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  onchip_memory_port_arbiter_if.slave  m0,
  onchip_memory_port_arbiter_if.slave  m1,
  onchip_mem_port_if.master            mem
);

  logic [1:0]        cmd;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              we;
  rd_tag_t           tag_d;
  rd_tag_t           tag_out;
  rd_tag_t           pipe_q [READ_LATENCY];

  assign cmd = {m1.read | m1.write,
                m0.read | m0.write};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (cmd),
    .grant   (gnt)
  );

  assign m0.waitrequest = ~reset_n
                        | (cmd[0] & ~gnt[0]);
  assign m1.waitrequest = ~reset_n
                        | (cmd[1] & ~gnt[1]);

  always_comb begin
    addr  = '0;
    be    = '0;
    wdata = '0;
    we    = 1'b0;
    unique case (1'b1)
      gnt[0]: begin
        addr  = m0.address;
        be    = m0.byteenable;
        wdata = m0.writedata;
        we    = m0.write;
      end
      gnt[1]: begin
        addr  = m1.address;
        be    = m1.byteenable;
        wdata = m1.writedata;
        we    = m1.write;
      end
      default: ;
    endcase
  end

  assign mem.chipselect = |gnt;
  assign mem.write      = we;
  assign mem.address    = addr;
  assign mem.byteenable = be;
  assign mem.writedata  = wdata;
  assign mem.clken      = 1'b1;

  // A read with write also set is dropped: write wins.
  assign tag_d.vld = (gnt[0] & m0.read & ~m0.write)
                   | (gnt[1] & m1.read & ~m1.write);
  assign tag_d.id  = gnt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_d;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[READ_LATENCY-1];

  assign m0.readdatavalid = tag_out.vld
                          & (tag_out.id == 1'b0);
  assign m1.readdatavalid = tag_out.vld
                          & (tag_out.id == 1'b1);
  assign m0.readdata = mem.readdata;
  assign m1.readdata = mem.readdata;

endmodule

// File: tb/tb_onchip_memory_port_arbiter.sv
// Directed scoreboard bench: latency-1 and latency-2
// arbiters, each in front of a behavioural memory.
module tb_onchip_memory_port_arbiter;
  import onchip_mem_pkg::*;

  typedef struct {
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] d;
  } cmd_t;

  typedef struct {
    bit                owner;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  typedef struct {
    logic              wr0, wr1, rdv0, rdv1, cs, we;
    logic [DATA_W-1:0] rdd0, rdd1, wd;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
  } obs_t;

  logic clk = 1'b0;
  logic rst1_n, rst2_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   illegal_cnt = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [DATA_W-1:0] memA [int];
  logic [DATA_W-1:0] memB [int];
  logic [DATA_W-1:0] refA [int];
  logic [DATA_W-1:0] refB [int];
  logic [DATA_W-1:0] rdA, rdB1, rdB2;

  onchip_memory_port_arbiter_if r0a ();
  onchip_memory_port_arbiter_if r1a ();
  onchip_memory_port_arbiter_if r0b ();
  onchip_memory_port_arbiter_if r1b ();
  onchip_mem_port_if mema ();
  onchip_mem_port_if memb ();

  onchip_memory_port_arbiter #(
    .READ_LATENCY (1)
  ) dut_a (
    .clk     (clk),
    .reset_n (rst1_n),
    .m0      (r0a),
    .m1      (r1a),
    .mem     (mema)
  );

  onchip_memory_port_arbiter #(
    .READ_LATENCY (2)
  ) dut_b (
    .clk     (clk),
    .reset_n (rst2_n),
    .m0      (r0b),
    .m1      (r1b),
    .mem     (memb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] pat(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] nw,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] memrd(
    input bit b, input int a
  );
    if (b) return memB.exists(a) ? memB[a] : pat(a);
    return memA.exists(a) ? memA[a] : pat(a);
  endfunction

  function automatic logic [DATA_W-1:0] refrd(
    input bit b, input int a
  );
    if (b) return refB.exists(a) ? refB[a] : pat(a);
    return refA.exists(a) ? refA[a] : pat(a);
  endfunction

  // Behavioural memories behind each arbiter.
  always @(posedge clk) begin
    if (mema.chipselect) begin
      if (mema.write)
        memA[int'(mema.address)] = merge(
          memrd(0, int'(mema.address)),
          mema.writedata, mema.byteenable);
      else
        rdA <= memrd(0, int'(mema.address));
    end
    if (memb.chipselect) begin
      if (memb.write)
        memB[int'(memb.address)] = merge(
          memrd(1, int'(memb.address)),
          memb.writedata, memb.byteenable);
      else
        rdB1 <= memrd(1, int'(memb.address));
    end
    rdB2 <= rdB1;
  end

  assign mema.readdata = rdA;
  assign memb.readdata = rdB2;

  task automatic chk(
    input string      tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk_nop();
    cmd_t c;
    c.rd = 0; c.wr = 0; c.a = '0; c.be = '0; c.d = '0;
    return c;
  endfunction

  function automatic cmd_t mk_rd(input int a);
    cmd_t c;
    c = mk_nop();
    c.rd = 1; c.a = ADDR_W'(a); c.be = '1;
    return c;
  endfunction

  function automatic cmd_t mk_wr(
    input int a, input logic [DATA_W-1:0] d,
    input logic [BE_W-1:0] be
  );
    cmd_t c;
    c = mk_nop();
    c.wr = 1; c.a = ADDR_W'(a); c.be = be; c.d = d;
    return c;
  endfunction

  function automatic obs_t sample(input bit b);
    obs_t o;
    if (!b) begin
      o.wr0 = r0a.waitrequest; o.wr1 = r1a.waitrequest;
      o.rdv0 = r0a.readdatavalid;
      o.rdv1 = r1a.readdatavalid;
      o.rdd0 = r0a.readdata; o.rdd1 = r1a.readdata;
      o.cs = mema.chipselect; o.we = mema.write;
      o.wd = mema.writedata; o.addr = mema.address;
      o.be = mema.byteenable;
    end else begin
      o.wr0 = r0b.waitrequest; o.wr1 = r1b.waitrequest;
      o.rdv0 = r0b.readdatavalid;
      o.rdv1 = r1b.readdatavalid;
      o.rdd0 = r0b.readdata; o.rdd1 = r1b.readdata;
      o.cs = memb.chipselect; o.we = memb.write;
      o.wd = memb.writedata; o.addr = memb.address;
      o.be = memb.byteenable;
    end
    return o;
  endfunction

  task automatic drive(
    input bit b, input cmd_t c0, input cmd_t c1
  );
    if (!b) begin
      r0a.read = c0.rd; r0a.write = c0.wr;
      r0a.address = c0.a; r0a.byteenable = c0.be;
      r0a.writedata = c0.d;
      r1a.read = c1.rd; r1a.write = c1.wr;
      r1a.address = c1.a; r1a.byteenable = c1.be;
      r1a.writedata = c1.d;
    end else begin
      r0b.read = c0.rd; r0b.write = c0.wr;
      r0b.address = c0.a; r0b.byteenable = c0.be;
      r0b.writedata = c0.d;
      r1b.read = c1.rd; r1b.write = c1.wr;
      r1b.address = c1.a; r1b.byteenable = c1.be;
      r1b.writedata = c1.d;
    end
  endtask

  // One cycle: drive, check grant/mux, log outcome.
  task automatic step(
    input bit b, input cmd_t c0, input cmd_t c1,
    input int g
  );
    obs_t o;
    cmd_t c;
    exp_t e;
    int   rl;
    rl = b ? 2 : 1;
    drive(b, c0, c1);
    @(negedge clk);
    o = sample(b);
    chk("wait0", 64'(o.wr0),
        64'((c0.rd || c0.wr) && g != 0));
    chk("wait1", 64'(o.wr1),
        64'((c1.rd || c1.wr) && g != 1));
    chk("chipsel", 64'(o.cs), 64'(g >= 0));
    if (g >= 0) begin
      c = (g == 1) ? c1 : c0;
      chk("mem_addr", 64'(o.addr), 64'(c.a));
      chk("mem_write", 64'(o.we), 64'(c.wr));
      if (c.wr) begin
        chk("mem_wdata", 64'(o.wd), 64'(c.d));
        chk("mem_be", 64'(o.be), 64'(c.be));
        if (b) refB[int'(c.a)] = merge(
          refrd(b, int'(c.a)), c.d, c.be);
        else refA[int'(c.a)] = merge(
          refrd(b, int'(c.a)), c.d, c.be);
      end else if (c.rd) begin
        e.owner = (g == 1);
        e.data  = refrd(b, int'(c.a));
        e.due   = cyc + rl;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
      end
    end else begin
      chk("idle_addr", 64'(o.addr), 64'(0));
      chk("idle_we", 64'(o.we), 64'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input bit b);
    obs_t o;
    o = sample(b);
    chk("rst_wait0", 64'(o.wr0), 64'(1));
    chk("rst_wait1", 64'(o.wr1), 64'(1));
    chk("rst_cs", 64'(o.cs), 64'(0));
    chk("rst_rdv", 64'({o.rdv1, o.rdv0}), 64'(0));
  endtask

  task automatic mon(input bit b);
    obs_t o;
    exp_t e;
    int   n;
    o = sample(b);
    n = b ? qb.size() : qa.size();
    if (o.rdv0 || o.rdv1) begin
      if (n == 0) begin
        chk("rdv_unexpected",
            64'({o.rdv1, o.rdv0}), 64'(0));
      end else begin
        e = b ? qb.pop_front() : qa.pop_front();
        chk("rdv_onehot", 64'(o.rdv0 & o.rdv1), 64'(0));
        chk("rdv_owner", 64'(o.rdv1), 64'(e.owner));
        chk("rdata", 64'(o.rdv1 ? o.rdd1 : o.rdd0),
            64'(e.data));
        chk("rdv_cycle", 64'(cyc), 64'(e.due));
      end
    end
  endtask

  always @(negedge clk) mon(1'b0);
  always @(negedge clk) mon(1'b1);

  always @(negedge clk)
    if (rst1_n && r1a.read && r1a.write) begin
      illegal_cnt++;
      $display("note: m1 read+write together, cycle %0d",
               cyc);
    end

  initial begin
    cmd_t c0, c1;
    int   i0, i1, g;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    drive(0, mk_nop(), mk_nop());
    drive(1, mk_nop(), mk_nop());
    r0a.read = 1'b1;
    repeat (2) begin
      @(negedge clk);
      rst_chk(0);
      rst_chk(1);
    end
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    step(0, mk_nop(), mk_nop(), -1);

    // Contention: m0 first, then strict alternation.
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 16; k++) begin
      c0 = (i0 < 8) ? mk_rd(i0) : mk_nop();
      c1 = (i1 < 8) ? mk_rd(32'h100 + i1) : mk_nop();
      g  = k % 2;
      step(0, c0, c1, g);
      if (g == 0) i0++;
      else        i1++;
    end
    step(0, mk_nop(), mk_nop(), -1);

    step(0, mk_wr(16'h0010, 32'hDEADBEEF, 4'hF),
         mk_nop(), 0);
    step(0, mk_rd(16'h0010), mk_nop(), 0);
    step(0, mk_nop(), mk_nop(), -1);

    step(0, mk_wr(16'h7FFF, 32'hFFFFFFFF, 4'hF),
         mk_nop(), 0);
    step(0, mk_wr(16'h7FFF, 32'h11223344, 4'h3),
         mk_nop(), 0);
    step(0, mk_rd(16'h7FFF), mk_nop(), 0);
    step(0, mk_nop(), mk_nop(), -1);

    c1 = mk_wr(16'h0020, 32'hA5A5A5A5, 4'hF);
    c1.rd = 1'b1;
    step(0, mk_nop(), c1, 1);
    step(0, mk_nop(), mk_nop(), -1);
    step(0, mk_nop(), mk_rd(16'h0020), 1);
    step(0, mk_nop(), mk_nop(), -1);
    chk("illegal_flagged", 64'(illegal_cnt), 64'(1));

    // Reset lands while an m0 read is in flight.
    step(0, mk_rd(16'h0010), mk_nop(), 0);
    rst1_n = 1'b0;
    qa.delete();
    drive(0, mk_rd(16'h0010), mk_rd(16'h7FFF));
    repeat (2) begin
      @(negedge clk);
      rst_chk(0);
    end
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    step(0, mk_rd(16'h0010), mk_rd(16'h7FFF), 0);
    step(0, mk_nop(), mk_rd(16'h7FFF), 1);
    step(0, mk_nop(), mk_nop(), -1);
    step(0, mk_nop(), mk_nop(), -1);

    step(1, mk_rd(5), mk_nop(), 0);
    step(1, mk_rd(6),
         mk_wr(16'h0105, 32'h12345678, 4'hF), 1);
    step(1, mk_rd(6), mk_nop(), 0);
    step(1, mk_rd(7), mk_rd(16'h0105), 1);
    step(1, mk_rd(7), mk_rd(16'h0106), 0);
    step(1, mk_nop(), mk_rd(16'h0106), 1);
    step(1, mk_rd(16'h7FFF), mk_nop(), 0);
    repeat (3) step(1, mk_nop(), mk_nop(), -1);

    chk("qa_drained", 64'(qa.size()), 64'(0));
    chk("qb_drained", 64'(qb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
